// File: rtl/mmio_rsp_arb.sv
// -----------------------------------------------------------------------------
// mmio_rsp_arb
//
// Round-robin arbiter that shares the single CCI-P MMIO read-response channel
// (tx.c2) between several register-bank responders. Each responder offers a
// tid/data pair with a valid/ready handshake. One responder is granted per
// cycle, and its response is registered toward tx.c2 one cycle later.
//
// Ports:
//   clk        AFU clock
//   rst_n      asynchronous active-low reset
//   src_valid  per-source response pending
//   src_ready  per-source grant (combinational, one-hot or zero)
//   src_tid    packed tids, source i at [i*TID_W +: TID_W]
//   src_data   packed data, source i at [i*DATA_W +: DATA_W]
//   rsp_valid  registered response strobe (tx.c2.mmioRdValid)
//   rsp_tid    registered tid (tx.c2.hdr.tid)
//   rsp_data   registered data (tx.c2.data)
//   rsp_src    index of the source behind the current response (debug)
//   rsp_cnt    total responses issued
//
// Build option:
//   MMIO_RSP_ARB_CNT_EN  when defined, rsp_cnt is a wrapping 32-bit count of
//                        rsp_valid cycles; otherwise rsp_cnt is tied to 0 and
//                        no counter flops exist.
// -----------------------------------------------------------------------------
module mmio_rsp_arb #(
    parameter int NUM_SRC = 4,
    parameter int TID_W   = 9,
    parameter int DATA_W  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*TID_W-1:0]     src_tid,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic                         rsp_valid,
    output logic [TID_W-1:0]             rsp_tid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [$clog2(NUM_SRC)-1:0]   rsp_src,
    output logic [31:0]                  rsp_cnt
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef logic [IDX_W-1:0] idx_t;

    // Index of the most recently granted source; the search starts one past it.
    idx_t                ptr;
    idx_t                grant_idx;
    logic                grant_any;
    logic [NUM_SRC-1:0]  grant_oh;

    // Walk the sources in rotating order starting after the last grant and
    // take the first one with a pending response. The modulo keeps the
    // rotation correct for source counts that are not a power of two.
    always_comb begin : arb_search
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = (int'(ptr) + k) % NUM_SRC;
            if (!grant_any && src_valid[idx_t'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = idx_t'(cand);
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // No grant may be visible while the block is held in reset, otherwise a
    // source could believe its response was consumed and then lose it.
    assign src_ready = rst_n ? grant_oh : '0;

    // Response register and round-robin pointer. The channel has no
    // backpressure, so every grant becomes exactly one response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= idx_t'(NUM_SRC - 1);
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            rsp_src   <= '0;
        end else begin
            rsp_valid <= grant_any;
            if (grant_any) begin
                ptr      <= grant_idx;
                rsp_tid  <= src_tid[int'(grant_idx)*TID_W +: TID_W];
                rsp_data <= src_data[int'(grant_idx)*DATA_W +: DATA_W];
                rsp_src  <= grant_idx;
            end
        end
    end

`ifdef MMIO_RSP_ARB_CNT_EN
    // Counts cycles in which a response is presented to tx.c2; wraps at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_cnt <= '0;
        end else if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 32'd1;
        end
    end
`else
    assign rsp_cnt = '0;
`endif

endmodule

// File: tb/tb_mmio_rsp_arb.sv
// -----------------------------------------------------------------------------
// tb_mmio_rsp_arb
//
// Self-checking bench for mmio_rsp_arb (NUM_SRC=4, TID_W=9, DATA_W=64).
// Directed scenarios plus a randomized run against a reference model that
// keeps the last granted index as a plain integer and predicts grants and
// responses with modular arithmetic. Counter checks follow
// MMIO_RSP_ARB_CNT_EN.
// -----------------------------------------------------------------------------
module tb_mmio_rsp_arb;

    localparam int NUM_SRC = 4;
    localparam int TID_W   = 9;
    localparam int DATA_W  = 64;
    localparam int IDX_W   = $clog2(NUM_SRC);

    logic                        clk;
    logic                        rst_n;
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC-1:0]          src_ready;
    logic [NUM_SRC*TID_W-1:0]    src_tid;
    logic [NUM_SRC*DATA_W-1:0]   src_data;
    logic                        rsp_valid;
    logic [TID_W-1:0]            rsp_tid;
    logic [DATA_W-1:0]           rsp_data;
    logic [IDX_W-1:0]            rsp_src;
    logic [31:0]                 rsp_cnt;

    logic [TID_W-1:0]            tid_a  [NUM_SRC];
    logic [DATA_W-1:0]           data_a [NUM_SRC];

    int checks;
    int errors;

    // Reference model state
    int                 m_ptr;
    logic               m_rsp_v;
    logic [TID_W-1:0]   m_tid;
    logic [DATA_W-1:0]  m_data;
    int                 m_src;
    logic [31:0]        m_cnt;

    mmio_rsp_arb #(
        .NUM_SRC (NUM_SRC),
        .TID_W   (TID_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_tid   (src_tid),
        .src_data  (src_data),
        .rsp_valid (rsp_valid),
        .rsp_tid   (rsp_tid),
        .rsp_data  (rsp_data),
        .rsp_src   (rsp_src),
        .rsp_cnt   (rsp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        src_tid  = '0;
        src_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_tid[i*TID_W +: TID_W]    = tid_a[i];
            src_data[i*DATA_W +: DATA_W] = data_a[i];
        end
    end

    // Round-robin rule: first pending source after the last granted one.
    function automatic int model_pick(input logic [NUM_SRC-1:0] v, input int last);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (v[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
        end
        return -1;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input int g);
        logic [NUM_SRC-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr   = NUM_SRC - 1;
        m_rsp_v = 1'b0;
        m_tid   = '0;
        m_data  = '0;
        m_src   = 0;
        m_cnt   = '0;
    endtask

    // Advance the model across one rising edge given the grant made before it.
    task automatic model_clock(input int g);
        if (m_rsp_v) m_cnt = m_cnt + 32'd1;
        if (g >= 0) begin
            m_ptr   = g;
            m_rsp_v = 1'b1;
            m_tid   = tid_a[g];
            m_data  = data_a[g];
            m_src   = g;
        end else begin
            m_rsp_v = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef MMIO_RSP_ARB_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        src_valid = '0;
        rst_n     = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        model_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            tid_a[i]  = TID_W'($urandom);
            data_a[i] = {$urandom, $urandom};
        end
        src_valid = '1;
        @(posedge clk); #1;
        checks++;
        if (src_ready !== '0) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", src_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_tid !== '0 || rsp_data !== '0 || rsp_src !== '0) begin
            errors++; $display("[TB] FAIL reset_rsp: got v=%b tid=%h data=%h src=%0d expected all 0",
                               rsp_valid, rsp_tid, rsp_data, rsp_src);
        end
        checks++;
        if (rsp_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", rsp_cnt);
        end
        src_valid = '0;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_all_valid();
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            tid_a[i]  = TID_W'(9'h010 + i);
            data_a[i] = {$urandom, $urandom};
        end
        src_valid = '1;
        for (int c = 0; c < 2 * NUM_SRC; c++) begin
            @(negedge clk);
            checks++;
            if (src_ready !== onehot(c % NUM_SRC)) begin
                errors++; $display("[TB] FAIL all_valid_ready c=%0d: got %b expected %b",
                                   c, src_ready, onehot(c % NUM_SRC));
            end
            @(posedge clk); #1;
            model_clock(model_pick(src_valid, m_ptr));
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tid !== TID_W'(9'h010 + (c % NUM_SRC))) begin
                errors++; $display("[TB] FAIL all_valid_rsp c=%0d: got v=%b tid=%h expected v=1 tid=%h",
                                   c, rsp_valid, rsp_tid, 9'h010 + (c % NUM_SRC));
            end
            checks++;
            if (rsp_data !== m_data || rsp_src !== IDX_W'(m_src)) begin
                errors++; $display("[TB] FAIL all_valid_data c=%0d: got %h/%0d expected %h/%0d",
                                   c, rsp_data, rsp_src, m_data, m_src);
            end
        end
        src_valid = '0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_single_src();
        do_reset();
        tid_a[2]  = 9'h055;
        data_a[2] = 64'hDEAD_BEEF_0000_0002;
        src_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) src_valid = '0;
            @(negedge clk);
            checks++;
            if (src_ready !== ((c == 3) ? 4'b0000 : 4'b0100)) begin
                errors++; $display("[TB] FAIL single_ready c=%0d: got %b", c, src_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== (c != 3)) begin
                errors++; $display("[TB] FAIL single_valid c=%0d: got %b expected %b", c, rsp_valid, c != 3);
            end
            if (c != 3) begin
                checks++;
                if (rsp_tid !== 9'h055 || rsp_data !== 64'hDEAD_BEEF_0000_0002 || rsp_src !== 2'd2) begin
                    errors++; $display("[TB] FAIL single_rsp c=%0d: got %h/%h/%0d expected 055/deadbeef00000002/2",
                                       c, rsp_tid, rsp_data, rsp_src);
                end
            end
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_wrap();
        logic [NUM_SRC-1:0] vseq [3];
        logic [NUM_SRC-1:0] rseq [3];
        vseq = '{4'b0010, 4'b0011, 4'b0010};
        rseq = '{4'b0010, 4'b0001, 4'b0010};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            src_valid = vseq[c];
            @(negedge clk);
            checks++;
            if (src_ready !== rseq[c]) begin
                errors++; $display("[TB] FAIL wrap_ready c=%0d: got %b expected %b", c, src_ready, rseq[c]);
            end
            @(posedge clk); #1;
        end
        src_valid = '0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_idle_src3();
        do_reset();
        tid_a[3]  = TID_W'($urandom);
        data_a[3] = {$urandom, $urandom};
        for (int c = 0; c < 5; c++) begin
            src_valid = (c == 2) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== (c == 2)) begin
                errors++; $display("[TB] FAIL idle_valid c=%0d: got %b expected %b", c, rsp_valid, c == 2);
            end
            if (c == 2) begin
                checks++;
                if (rsp_src !== 2'd3 || rsp_tid !== tid_a[3] || rsp_data !== data_a[3]) begin
                    errors++; $display("[TB] FAIL idle_rsp: got %0d/%h/%h expected 3/%h/%h",
                                       rsp_src, rsp_tid, rsp_data, tid_a[3], data_a[3]);
                end
            end
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid();
        do_reset();
        src_valid = 4'b1111;
        @(posedge clk); #1;
        // A response is now registered; async reset must drop it at once.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || src_ready !== '0) begin
            errors++; $display("[TB] FAIL reset_async: got v=%b ready=%b expected 0/0000", rsp_valid, src_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Reset lands in the same cycle as a pending transfer.
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_same_cycle: got v=%b expected 0", rsp_valid);
        end
        model_reset();
        src_valid = 4'b1010;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL reset_rearb: got %b expected 0010", src_ready);
        end
        @(posedge clk); #1;
        src_valid = '0;
        @(posedge clk); #1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_random();
        logic [NUM_SRC-1:0] pend;
        int                 waits [NUM_SRC];
        int                 g;
        int                 worst;
        do_reset();
        pend = '0;
        for (int i = 0; i < NUM_SRC; i++) waits[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    tid_a[i]  = TID_W'($urandom);
                    data_a[i] = {$urandom, $urandom};
                end
            end
            src_valid = pend;
            @(negedge clk);
            g = model_pick(src_valid, m_ptr);
            checks++;
            if (src_ready !== onehot(g)) begin
                errors++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, src_ready, onehot(g));
            end
            worst = 0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pend[i] && i != g) waits[i]++;
                else waits[i] = 0;
                if (waits[i] > worst) worst = waits[i];
            end
            checks++;
            if (worst > NUM_SRC - 1) begin
                errors++; $display("[TB] FAIL rand_fair c=%0d: got wait %0d expected <= %0d", c, worst, NUM_SRC - 1);
            end
            @(posedge clk); #1;
            model_clock(g);
            if (g >= 0) pend[g] = 1'b0;
            checks++;
            if (rsp_valid !== m_rsp_v) begin
                errors++; $display("[TB] FAIL rand_valid c=%0d: got %b expected %b", c, rsp_valid, m_rsp_v);
            end
            if (m_rsp_v) begin
                checks++;
                if (rsp_tid !== m_tid || rsp_data !== m_data || rsp_src !== IDX_W'(m_src)) begin
                    errors++; $display("[TB] FAIL rand_rsp c=%0d: got %h/%h/%0d expected %h/%h/%0d",
                                       c, rsp_tid, rsp_data, rsp_src, m_tid, m_data, m_src);
                end
            end
            checks++;
            if (rsp_cnt !== exp_cnt()) begin
                errors++; $display("[TB] FAIL rand_cnt c=%0d: got %0d expected %0d", c, rsp_cnt, exp_cnt());
            end
        end
        src_valid = '0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_counter();
        do_reset();
        tid_a[0]  = TID_W'($urandom);
        data_a[0] = {$urandom, $urandom};
        src_valid = 4'b0001;
        repeat (10) @(posedge clk);
        #1 src_valid = '0;
        repeat (2) @(posedge clk);
        #1;
`ifdef MMIO_RSP_ARB_CNT_EN
        checks++;
        if (rsp_cnt !== 32'd10) begin
            errors++; $display("[TB] FAIL cnt_ten: got %0d expected 10", rsp_cnt);
        end
        force dut.rsp_cnt = 32'hFFFF_FFFF;
        #1 release dut.rsp_cnt;
        #1;
        checks++;
        if (rsp_cnt !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL cnt_preload: got %h expected ffffffff", rsp_cnt);
        end
        @(posedge clk); #1;
        src_valid = 4'b0001;
        @(posedge clk); #1;
        src_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL cnt_wrap: got %h expected 0", rsp_cnt);
        end
`else
        checks++;
        if (rsp_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL cnt_tied: got %0d expected 0", rsp_cnt);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        src_valid = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            tid_a[i]  = '0;
            data_a[i] = '0;
        end
        model_reset();
        #1;
        test_reset();
        test_all_valid();
        test_single_src();
        test_wrap();
        test_idle_src3();
        test_reset_mid();
        test_random();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
